// File: rtl/cache_pkg.sv
// Shared cache geometry and write-back FSM state encoding, also used by the
// data-array and tag blocks.
package cache_pkg;
  localparam int LINE_BYTES = 32;
  localparam int BEAT_BYTES = 4;
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_SEND = 2'd1,
    WB_DONE = 2'd2
  } wb_state_t;
endpackage

// File: rtl/cache_line_writeback_if.sv
// Eviction request side and memory beat side of the line write-back engine.
interface cache_line_writeback_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int BEAT_BYTES = 4
);
  logic                    wbReq;
  logic [ADDR_W-1:0]       wbAddr;
  logic [8*LINE_BYTES-1:0] lineData;
  logic                    wbBusy;
  logic                    wbDone;
  logic                    memValid;
  logic                    memReady;
  logic [ADDR_W-1:0]       memAddr;
  logic [8*BEAT_BYTES-1:0] memData;
  logic                    memLast;

  modport slave (
    input  wbReq, wbAddr, lineData, memReady,
    output wbBusy, wbDone, memValid, memAddr, memData, memLast
  );

  modport master (
    output wbReq, wbAddr, lineData, memReady,
    input  wbBusy, wbDone, memValid, memAddr, memData, memLast
  );
endinterface

// File: rtl/cache_line_writeback_wb_beat_mux.sv
// Selects beat sel_i of a captured line; byte 0 of the line lands in the low
// byte of beat 0.
module wb_beat_mux #(
  parameter  int LINE_BYTES = 32,
  parameter  int BEAT_BYTES = 4,
  localparam int BEATS      = LINE_BYTES / BEAT_BYTES,
  localparam int SEL_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic [8*LINE_BYTES-1:0] line_i,
  input  logic [SEL_W-1:0]        sel_i,
  output logic [8*BEAT_BYTES-1:0] beat_o
);
  logic [BEATS-1:0][8*BEAT_BYTES-1:0] beats;

  assign beats  = line_i;
  assign beat_o = beats[sel_i];
endmodule

// File: rtl/cache_line_writeback.sv
// Captures an evicted dirty line in one cycle and streams it to memory as
// fixed-size beats over valid/ready.
module cache_line_writeback #(
  parameter int LINE_BYTES = cache_pkg::LINE_BYTES,
  parameter int BEAT_BYTES = cache_pkg::BEAT_BYTES,
  parameter int ADDR_W     = 32
) (
  input logic                     clk,
  input logic                     reset,
  cache_line_writeback_if.slave   bus
);
  import cache_pkg::*;

  localparam int NBEATS = LINE_BYTES / BEAT_BYTES;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BOFF_W = $clog2(BEAT_BYTES);

  wb_state_t               state_q;
  logic [8*LINE_BYTES-1:0] line_q;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_W-1:0]        beat_q;
  logic                    valid_q, done_q, busy_q, last_q;

  logic [ADDR_W-1:0]       base_d;
  logic [CNT_W-1:0]        beat_d;
  logic                    last_beat;

  assign base_d    = {bus.wbAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat_d    = beat_q + 1'b1;
  assign last_beat = (beat_q == CNT_W'(NBEATS-1));

  // All control outputs are registered; memReady only affects next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WB_IDLE;
      line_q  <= '0;
      base_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: if (bus.wbReq) begin
          line_q  <= bus.lineData;
          base_q  <= base_d;
          beat_q  <= '0;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          last_q  <= (NBEATS == 1);
          state_q <= WB_SEND;
        end
        WB_SEND: if (bus.memReady) begin
          if (last_beat) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= WB_DONE;
          end else begin
            beat_q <= beat_d;
            last_q <= (beat_d == CNT_W'(NBEATS-1));
          end
        end
        WB_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          beat_q  <= '0;
          state_q <= WB_IDLE;
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

  wb_beat_mux #(
    .LINE_BYTES(LINE_BYTES),
    .BEAT_BYTES(BEAT_BYTES)
  ) u_mux (
    .line_i(line_q),
    .sel_i (beat_q),
    .beat_o(bus.memData)
  );

  // Base is line-aligned, so the beat offset never carries out of the line.
  assign bus.memAddr  = base_q + (ADDR_W'(beat_q) << BOFF_W);
  assign bus.memValid = valid_q;
  assign bus.memLast  = last_q;
  assign bus.wbDone   = done_q;
  assign bus.wbBusy   = busy_q;
endmodule

// File: tb/tb_cache_line_writeback.sv
// Directed bench for the line write-back engine.
module tb_cache_line_writeback;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_line_writeback_if #(.ADDR_W(32), .LINE_BYTES(32), .BEAT_BYTES(4)) bus ();

  cache_line_writeback #(.LINE_BYTES(32), .BEAT_BYTES(4), .ADDR_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] pat(int b, int off);
    return {8'(off + 4*b + 3), 8'(off + 4*b + 2), 8'(off + 4*b + 1), 8'(off + 4*b)};
  endfunction

  task automatic load_line(int off);
    for (int i = 0; i < 32; i++) bus.lineData[8*i +: 8] = 8'(off + i);
  endtask

  task automatic test_reset();
    bus.wbReq    = 1'b1;
    bus.wbAddr   = $urandom;
    bus.memReady = 1'b1;
    for (int i = 0; i < 8; i++) bus.lineData[32*i +: 32] = $urandom;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.wbBusy, bus.wbDone, bus.memValid, bus.memLast} !== 4'b0 ||
        bus.memAddr !== 32'h0 || bus.memData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b valid=%b last=%b addr=%h data=%h, required all 0",
               bus.wbBusy, bus.wbDone, bus.memValid, bus.memLast, bus.memAddr, bus.memData);
    end
    bus.wbReq = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.memValid !== 1'b0 || bus.wbBusy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: valid=%b busy=%b, required 0 0", c, bus.memValid, bus.wbBusy);
      end
    end
  endtask

  task automatic test_nominal();
    @(negedge clk);
    load_line(0);
    bus.wbAddr = 32'h0000_1040; bus.wbReq = 1'b1; bus.memReady = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.wbReq = 1'b0;
      if (c <= 8) begin
        n_tests++;
        if (bus.memValid !== 1'b1 || bus.memData !== pat(c-1, 0) ||
            bus.memAddr !== 32'h1040 + 32'(4*(c-1)) || bus.memLast !== (c == 8) ||
            bus.wbBusy !== 1'b1 || bus.wbDone !== 1'b0) begin
          n_fail++;
          $display("FAIL nominal_beat%0d: valid=%b data=%h addr=%h last=%b busy=%b done=%b, required 1 %h %h %b 1 0",
                   c-1, bus.memValid, bus.memData, bus.memAddr, bus.memLast, bus.wbBusy, bus.wbDone,
                   pat(c-1, 0), 32'h1040 + 32'(4*(c-1)), c == 8);
        end
      end else if (c == 9) begin
        n_tests++;
        if (bus.wbDone !== 1'b1 || bus.memValid !== 1'b0 || bus.wbBusy !== 1'b1) begin
          n_fail++;
          $display("FAIL nominal_done: done=%b valid=%b busy=%b, required 1 0 1", bus.wbDone, bus.memValid, bus.wbBusy);
        end
      end else begin
        n_tests++;
        if (bus.wbDone !== 1'b0 || bus.wbBusy !== 1'b0 || bus.memLast !== 1'b0) begin
          n_fail++;
          $display("FAIL nominal_idle: done=%b busy=%b last=%b, required 0 0 0", bus.wbDone, bus.wbBusy, bus.memLast);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int idx;
    @(negedge clk);
    load_line(0);
    bus.wbAddr = 32'h0000_1040; bus.wbReq = 1'b1; bus.memReady = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.wbReq = 1'b0;
      idx = (c < 3) ? c - 1 : (c <= 6) ? 2 : c - 4;
      if (c <= 11) begin
        n_tests++;
        if (bus.memValid !== 1'b1 || bus.memData !== pat(idx, 0) ||
            bus.memAddr !== 32'h1040 + 32'(4*idx) || bus.wbDone !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_c%0d: valid=%b data=%h addr=%h done=%b, required 1 %h %h 0",
                   c, bus.memValid, bus.memData, bus.memAddr, bus.wbDone, pat(idx, 0), 32'h1040 + 32'(4*idx));
        end
      end else begin
        n_tests++;
        if (bus.wbDone !== (c == 12) || bus.memValid !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_done_c%0d: done=%b valid=%b, required %b 0", c, bus.wbDone, bus.memValid, c == 12);
        end
      end
      if (c == 3) bus.memReady = 1'b0;
      if (c == 6) bus.memReady = 1'b1;
    end
  endtask

  task automatic test_unaligned();
    @(negedge clk);
    load_line(8'hA0);
    bus.wbAddr = 32'h0000_1047; bus.wbReq = 1'b1; bus.memReady = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.wbReq = 1'b0;
      bus.lineData = '1;
      bus.wbAddr = 32'hDEAD_BEEF;
      if (c <= 8) begin
        n_tests++;
        if (bus.memData !== pat(c-1, 8'hA0) || bus.memAddr !== 32'h1040 + 32'(4*(c-1))) begin
          n_fail++;
          $display("FAIL unaligned_beat%0d: data=%h addr=%h, required %h %h",
                   c-1, bus.memData, bus.memAddr, pat(c-1, 8'hA0), 32'h1040 + 32'(4*(c-1)));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_busy_req();
    int beats, dones;
    beats = 0; dones = 0;
    @(negedge clk);
    load_line(0);
    bus.wbAddr = 32'h0000_1040; bus.wbReq = 1'b1; bus.memReady = 1'b1;
    @(negedge clk);
    bus.wbReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.memValid) begin
        beats++;
        n_tests++;
        if (bus.memAddr[31:8] !== 24'h000010) begin
          n_fail++;
          $display("FAIL busy_addr: addr=%h, required within line 0x1040", bus.memAddr);
        end
      end
      if (bus.wbDone) dones++;
      bus.wbAddr = 32'h0000_2000;
      bus.wbReq  = (bus.memValid && bus.memAddr == 32'h104C) || bus.wbDone;
      @(negedge clk);
    end
    bus.wbReq = 1'b0;
    n_tests++;
    if (beats != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL busy_counts: beats=%0d dones=%0d, required 8 1", beats, dones);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load_line(0);
    bus.wbAddr = 32'h0000_1040; bus.wbReq = 1'b1; bus.memReady = 1'b1;
    repeat (5) begin
      @(negedge clk);
      bus.wbReq = 1'b0;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if (bus.memValid !== 1'b0 || bus.wbDone !== 1'b0 || bus.wbBusy !== 1'b0 || bus.memAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_abort: valid=%b done=%b busy=%b addr=%h, required 0 0 0 0",
               bus.memValid, bus.wbDone, bus.wbBusy, bus.memAddr);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.wbDone !== 1'b0 || bus.memValid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_quiet c=%0d: done=%b valid=%b, required 0 0", c, bus.wbDone, bus.memValid);
      end
    end
    load_line(8'h40);
    bus.wbAddr = 32'h0000_2080; bus.wbReq = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.wbReq = 1'b0;
      if (c == 1) begin
        n_tests++;
        if (bus.memValid !== 1'b1 || bus.memAddr !== 32'h2080 || bus.memData !== pat(0, 8'h40) || bus.memLast !== 1'b0) begin
          n_fail++;
          $display("FAIL midreset_restart: valid=%b addr=%h data=%h last=%b, required 1 00002080 %h 0",
                   bus.memValid, bus.memAddr, bus.memData, bus.memLast, pat(0, 8'h40));
        end
      end
      if (c == 9) begin
        n_tests++;
        if (bus.wbDone !== 1'b1) begin
          n_fail++;
          $display("FAIL midreset_done: done=%b, required 1", bus.wbDone);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.wbReq = 1'b0; bus.wbAddr = '0; bus.lineData = '0; bus.memReady = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_unaligned();
    test_busy_req();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
